// File: rtl/fc_lif_layer.sv
// Time-multiplexed fully-connected layer with leaky integrate-and-fire neurons.
// One activation plus its weight column per beat; bias, leak, fire and reset once per timestep.
module fc_lif_layer #(
  parameter int                     N_IN        = 49,
  parameter int                     N_OUT       = 10,
  parameter int                     X_W         = 3,
  parameter int                     X_FRAC      = 2,
  parameter int                     W_W         = 16,
  parameter int                     DECAY_SHIFT = 2,
  parameter logic signed [W_W-1:0]  THRESH      = 16'sh1000,
  parameter bit                     RESET_MODE  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear_v,
  input  logic                   x_valid,
  output logic                   x_ready,
  input  logic [X_W-1:0]         x_data,
  input  logic [N_OUT*W_W-1:0]   w_data,
  input  logic [N_OUT*W_W-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT-1:0]       spike_out,
  output logic [N_OUT*W_W-1:0]   v_out,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = W_W + X_W + $clog2(N_IN) + 1;

  typedef enum logic [2:0] {IDLE, ACC, SCALE, FIRE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [W_W-1:0]   i_q   [N_OUT];
  logic signed [W_W-1:0]   v_q   [N_OUT];

  logic signed [ACC_W-1:0] prod   [N_OUT];
  logic signed [W_W-1:0]   i_next [N_OUT];
  logic signed [W_W-1:0]   v_next [N_OUT];
  logic [N_OUT-1:0]        spike_next;
  logic                    beat;
  logic                    last_beat;

  // Clamp a wide signed value into W_W bits: in range iff all bits above the sign agree.
  function automatic logic signed [W_W-1:0] sat_w(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-W_W:0] top;
    top = a[ACC_W-1:W_W-1];
    if ((&top) || (~|top)) return a[W_W-1:0];
    else if (a[ACC_W-1])   return {1'b1, {(W_W-1){1'b0}}};
    else                   return {1'b0, {(W_W-1){1'b1}}};
  endfunction

  // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
  // ready never depends on valid, and a producer holds valid/data until the transfer.
  assign x_ready   = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
  assign beat      = x_valid & x_ready;
  assign last_beat = beat && (cnt_q == CNT_W'(N_IN - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (last_beat) state_d = SCALE;
      SCALE:   state_d = FIRE;
      FIRE:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [W_W-1:0]   scaled;
    logic signed [W_W-1:0]   leak;
    logic signed [W_W-1:0]   u;
    w_ext      = '0;
    x_ext      = ACC_W'($signed({1'b0, x_data}));
    scaled     = '0;
    leak       = '0;
    u          = '0;
    spike_next = '0;
    for (int n = 0; n < N_OUT; n++) begin
      prod[n]   = '0;
      i_next[n] = '0;
      v_next[n] = '0;
    end
    for (int n = 0; n < N_OUT; n++) begin
      w_ext         = ACC_W'($signed(w_data[n*W_W +: W_W]));
      prod[n]       = w_ext * x_ext;
      scaled        = sat_w(acc_q[n] >>> X_FRAC);
      i_next[n]     = sat_w(ACC_W'(scaled) + ACC_W'($signed(b[n*W_W +: W_W])));
      leak          = v_q[n] >>> DECAY_SHIFT;
      u             = sat_w(ACC_W'(leak) + ACC_W'(i_q[n]));
      spike_next[n] = (u >= THRESH);
      // u >= THRESH > 0 on a spike, so the subtraction cannot wrap.
      if (spike_next[n]) v_next[n] = RESET_MODE ? (u - THRESH) : '0;
      else               v_next[n] = u;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      spike_out <= '0;
      v_out     <= '0;
      for (int n = 0; n < N_OUT; n++) begin
        acc_q[n] <= '0;
        i_q[n]   <= '0;
        v_q[n]   <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          cnt_q <= '0;
          for (int n = 0; n < N_OUT; n++) begin
            acc_q[n] <= '0;
            if (clear_v) v_q[n] <= '0;
          end
        end
        ACC: if (beat) begin
          cnt_q <= cnt_q + CNT_W'(1);
          for (int n = 0; n < N_OUT; n++) acc_q[n] <= acc_q[n] + prod[n];
        end
        SCALE: for (int n = 0; n < N_OUT; n++) i_q[n] <= i_next[n];
        FIRE: begin
          out_valid <= 1'b1;
          spike_out <= spike_next;
          for (int n = 0; n < N_OUT; n++) begin
            v_q[n]                 <= v_next[n];
            v_out[n*W_W +: W_W]    <= v_next[n];
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_lif_layer.sv
// Directed bench for fc_lif_layer: hard-reset and subtract-reset instances share all inputs.
module tb_fc_lif_layer;
  localparam int N_IN  = 49;
  localparam int N_OUT = 10;
  localparam int X_W   = 3;
  localparam int W_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, clear_v = 1'b0, x_valid = 1'b0, out_ready = 1'b0;
  logic [X_W-1:0]       x_data = '0;
  logic [N_OUT*W_W-1:0] w_data = '0, b = '0;

  logic x_ready_h, out_valid_h, busy_h, x_ready_s, out_valid_s, busy_s;
  logic [N_OUT-1:0]     spike_h, spike_s;
  logic [N_OUT*W_W-1:0] v_h, v_s;
  logic [2:0]           state_h, state_s;

  logic [X_W-1:0] x_vec [N_IN];
  logic [W_W-1:0] w_vec [N_IN];
  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  fc_lif_layer #(.RESET_MODE(1'b0)) dut_h (
    .clk(clk), .rst(rst), .start(start), .clear_v(clear_v), .x_valid(x_valid),
    .x_ready(x_ready_h), .x_data(x_data), .w_data(w_data), .b(b),
    .out_valid(out_valid_h), .out_ready(out_ready), .spike_out(spike_h),
    .v_out(v_h), .busy(busy_h), .state_dbg(state_h));

  fc_lif_layer #(.RESET_MODE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .clear_v(clear_v), .x_valid(x_valid),
    .x_ready(x_ready_s), .x_data(x_data), .w_data(w_data), .b(b),
    .out_valid(out_valid_s), .out_ready(out_ready), .spike_out(spike_s),
    .v_out(v_s), .busy(busy_s), .state_dbg(state_s));

  function automatic logic [W_W-1:0] vsel(input logic [N_OUT*W_W-1:0] v, input int n);
    return v[n*W_W +: W_W];
  endfunction

  task automatic set_pattern(input logic [X_W-1:0] x0, input logic [X_W-1:0] xr,
                             input logic [W_W-1:0] w, input logic [W_W-1:0] b1);
    for (int i = 0; i < N_IN; i++) begin
      x_vec[i] = (i == 0) ? x0 : xr;
      w_vec[i] = w;
    end
    b = '0;
    b[W_W +: W_W] = b1;
  endtask

  // Starts a timestep, streams all beats (optionally idling every other cycle) and waits for out_valid.
  task automatic drive_pass(input bit clear, input bit gappy, output int cycles);
    int  idx;
    bit  done;
    idx = 0; done = 0; cycles = 0;
    @(negedge clk); start = 1'b1; clear_v = clear;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      start = 1'b0; clear_v = 1'b0; cycles++;
      if (out_valid_h || out_valid_s) done = 1;
      else if (idx < N_IN) begin
        if (gappy && (c % 2 == 0)) begin
          x_valid = 1'b0; x_data = X_W'($urandom_range(0, 7)); w_data = {N_OUT{16'(($urandom))}};
        end else begin
          x_valid = 1'b1; x_data = x_vec[idx]; w_data = {N_OUT{w_vec[idx]}};
          if (x_ready_h) idx++;
        end
      end else x_valid = 1'b0;
    end
    x_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL pass_timeout got no out_valid exp out_valid within 400 cycles"); end
  endtask

  task automatic accept();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom); clear_v = 1'($urandom); x_valid = 1'($urandom);
      out_ready = 1'($urandom); x_data = X_W'($urandom);
      w_data = {5{32'($urandom)}}; b = {5{32'($urandom)}};
    end
    #1;
    checks++;
    if ({out_valid_h, busy_h, x_ready_h, spike_h, v_h} !== '0) begin
      errors++; $display("FAIL reset_outputs_h got %h exp 0", {out_valid_h, busy_h, x_ready_h, spike_h, v_h});
    end
    checks++;
    if ({out_valid_s, busy_s, x_ready_s, spike_s, v_s} !== '0) begin
      errors++; $display("FAIL reset_outputs_s got %h exp 0", {out_valid_s, busy_s, x_ready_s, spike_s, v_s});
    end
    @(negedge clk);
    start = 1'b0; clear_v = 1'b0; x_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({x_ready_h, x_ready_s, busy_h} !== 3'b111) begin
      errors++; $display("FAIL start_x_ready got %b exp 111", {x_ready_h, x_ready_s, busy_h});
    end
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_uniform();
    set_pattern(3'd4, 3'd4, 16'h0100, 16'h0000);
    drive_pass(1'b1, 1'b0, lat);
    checks++;
    if (lat !== N_IN + 3) begin errors++; $display("FAIL uniform_latency got %0d exp %0d", lat, N_IN + 3); end
    checks++;
    if ({spike_h, spike_s} !== {2{10'h3FF}}) begin
      errors++; $display("FAIL uniform_spikes got %h %h exp 3ff 3ff", spike_h, spike_s);
    end
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (vsel(v_h, n) !== 16'd0 || vsel(v_s, n) !== 16'd8448) begin
        errors++; $display("FAIL uniform_v[%0d] got %0d %0d exp 0 8448", n,
                           $signed(vsel(v_h, n)), $signed(vsel(v_s, n)));
      end
    end
    accept();
    checks++;
    if ({out_valid_h, busy_h, out_valid_s, busy_s} !== 4'b0000) begin
      errors++; $display("FAIL uniform_release got %b exp 0000", {out_valid_h, busy_h, out_valid_s, busy_s});
    end
  endtask

  task automatic test_threshold();
    set_pattern(3'd2, 3'd0, 16'h2000, 16'hFFFF);
    drive_pass(1'b1, 1'b0, lat);
    checks++;
    if ({spike_h, spike_s} !== {2{10'h3FD}}) begin
      errors++; $display("FAIL thresh_spikes got %h %h exp 3fd 3fd", spike_h, spike_s);
    end
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (vsel(v_h, n) !== 16'((n == 1) ? 4095 : 0) || vsel(v_s, n) !== 16'((n == 1) ? 4095 : 0)) begin
        errors++; $display("FAIL thresh_v[%0d] got %0d %0d exp %0d", n,
                           $signed(vsel(v_h, n)), $signed(vsel(v_s, n)), (n == 1) ? 4095 : 0);
      end
    end
    accept();
    drive_pass(1'b0, 1'b0, lat);
    checks++;
    if ({spike_h, spike_s} !== {2{10'h3FF}}) begin
      errors++; $display("FAIL thresh_repeat_spikes got %h %h exp 3ff 3ff", spike_h, spike_s);
    end
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (vsel(v_h, n) !== 16'd0 || vsel(v_s, n) !== 16'((n == 1) ? 1022 : 0)) begin
        errors++; $display("FAIL thresh_repeat_v[%0d] got %0d %0d exp 0 %0d", n,
                           $signed(vsel(v_h, n)), $signed(vsel(v_s, n)), (n == 1) ? 1022 : 0);
      end
    end
    accept();
  endtask

  task automatic test_handshake();
    set_pattern(3'd4, 3'd4, 16'h0100, 16'h0000);
    drive_pass(1'b1, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      checks++;
      if ({out_valid_h, out_valid_s, busy_h, busy_s, x_ready_h, x_ready_s} !== 6'b111100) begin
        errors++; $display("FAIL stall_ctrl[%0d] got %b exp 111100", i,
                           {out_valid_h, out_valid_s, busy_h, busy_s, x_ready_h, x_ready_s});
      end
      checks++;
      if ({spike_h, spike_s} !== {2{10'h3FF}} || v_h !== '0 || v_s !== {N_OUT{16'd8448}}) begin
        errors++; $display("FAIL stall_data[%0d] got %h %h %h exp 3ff 3ff 0 and 8448 each", i,
                           spike_h, spike_s, v_s);
      end
      @(negedge clk);
    end
    start = 1'b0;
    accept();
    @(negedge clk);
    checks++;
    if ({busy_h, busy_s, out_valid_h} !== 3'b000) begin
      errors++; $display("FAIL stall_start_ignored got %b exp 000", {busy_h, busy_s, out_valid_h});
    end
  endtask

  task automatic test_saturation();
    set_pattern(3'd7, 3'd7, 16'h7FFF, 16'h0000);
    drive_pass(1'b1, 1'b0, lat);
    checks++;
    if ({spike_h, spike_s} !== {2{10'h3FF}} || v_h !== '0 || v_s !== {N_OUT{16'd28671}}) begin
      errors++; $display("FAIL sat_pos got %h %h %h exp 3ff 3ff 0 and 28671 each", spike_h, spike_s, v_s);
    end
    accept();
    set_pattern(3'd7, 3'd7, 16'h8000, 16'h0000);
    drive_pass(1'b1, 1'b0, lat);
    checks++;
    if ({spike_h, spike_s} !== '0 || v_h !== {N_OUT{16'h8000}} || v_s !== {N_OUT{16'h8000}}) begin
      errors++; $display("FAIL sat_neg got %h %h %h exp 0 0 and -32768 each", spike_h, spike_s, v_h);
    end
    accept();
    set_pattern(3'd7, 3'd7, 16'h0000, 16'h0000);
    drive_pass(1'b0, 1'b0, lat);
    checks++;
    if ({spike_h, spike_s} !== '0 || v_h !== {N_OUT{16'hE000}} || v_s !== {N_OUT{16'hE000}}) begin
      errors++; $display("FAIL sat_leak got %h %h %h exp 0 0 and -8192 each", spike_h, spike_s, v_h);
    end
    accept();
  endtask

  task automatic test_midpass_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      x_valid = 1'b1; x_data = 3'd4; w_data = {N_OUT{16'h0100}};
      @(negedge clk);
    end
    x_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid_h, busy_h, x_ready_h, spike_h, v_h, out_valid_s, busy_s, x_ready_s, spike_s, v_s} !== '0) begin
      errors++; $display("FAIL midpass_reset got busy %b %b x_ready %b %b exp all 0",
                         busy_h, busy_s, x_ready_h, x_ready_s);
    end
    @(negedge clk); rst = 1'b1;
    set_pattern(3'd2, 3'd0, 16'h2000, 16'hFFFF);
    drive_pass(1'b0, 1'b0, lat);
    checks++;
    if (lat !== N_IN + 3) begin errors++; $display("FAIL midpass_latency got %0d exp %0d", lat, N_IN + 3); end
    checks++;
    if ({spike_h, spike_s} !== {2{10'h3FD}}) begin
      errors++; $display("FAIL midpass_spikes got %h %h exp 3fd 3fd", spike_h, spike_s);
    end
    for (int n = 0; n < N_OUT; n++) begin
      checks++;
      if (vsel(v_h, n) !== 16'((n == 1) ? 4095 : 0) || vsel(v_s, n) !== 16'((n == 1) ? 4095 : 0)) begin
        errors++; $display("FAIL midpass_v[%0d] got %0d %0d exp %0d", n,
                           $signed(vsel(v_h, n)), $signed(vsel(v_s, n)), (n == 1) ? 4095 : 0);
      end
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_threshold();
    test_handshake();
    test_saturation();
    test_midpass_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fc_lif_layer.md
# fc_lif_layer

Parametrised, time-multiplexed fully-connected layer with built-in LIF neurons for the spiking classifier back end. It accepts one input activation per beat (1.2 unsigned spike count from pooling) together with that input's weight column, accumulates all N_OUT dot products in parallel, adds bias once per timestep, then performs the leaky integrate-and-fire update with internally held membrane potentials. It generalises the fixed 49×10 combinational FC stage by adding configurable sizes, saturating arithmetic, selectable reset mode and a valid/ready handshake.

## Interface
- N_IN, 49: input activations per timestep (beats per pass)
- N_OUT, 10: output neurons / accumulators
- X_W, 3: input activation width, unsigned
- X_FRAC, 2: fractional bits of input
- W_W, 16: weight, bias, membrane width, signed 3.13
- DECAY_SHIFT, 2: leak = arithmetic shift right of v_old
- THRESH, 16'sh1000: firing threshold (0.5 in 3.13)
- RESET_MODE, 0: 0 = hard reset to 0 after spike, 1 = subtract THRESH
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one timestep; accepted only in IDLE
- clear_v  in  1  sampled with accepted start; zero membranes before this timestep
- x_valid  in  1  input beat valid
- x_ready  out  1  high in ACC only
- x_data  in  X_W  activation, unsigned
- w_data  in  N_OUT*W_W  weight column for current beat; neuron n in [W_W*(n+1)-1 : W_W*n]
- b  in  N_OUT*W_W  biases, sampled in SCALE
- out_valid  out  1  spike/membrane result valid
- out_ready  in  1  consumer accepts result
- spike_out  out  N_OUT  spikes of current timestep
- v_out  out  N_OUT*W_W  updated membranes
- busy  out  1  state != IDLE

## Operation
- States: IDLE -> ACC (start) -> SCALE (N_IN-th beat accepted) -> FIRE (1 cycle) -> DONE -> IDLE (out_valid & out_ready).
- start outside IDLE ignored. On accepted start: accumulators and beat counter cleared; if clear_v, all membranes cleared to 0.
- ACC: beat = x_valid & x_ready. Per n: acc[n] += w[n] * $signed({1'b0,x_data}); acc width W_W+X_W+clog2(N_IN)+1, no overflow possible. Zero x still counts as a beat. Counter 0..N_IN-1; beat at count N_IN-1 moves to SCALE.
- SCALE: I[n] = sat_W(sat_W(acc[n] >>> X_FRAC) + b[n]); >>> is arithmetic (floor). sat_W clamps to [-2^(W_W-1), 2^(W_W-1)-1].
- FIRE: u = sat_W((v[n] >>> DECAY_SHIFT) + I[n]); spike = (u >= THRESH) signed. v[n] <= spike ? (RESET_MODE ? u - THRESH : 0) : u. spike_out, v_out registered; out_valid set.
- DONE: spike_out, v_out, out_valid held stable until out_ready; membranes retained across timesteps.
- Reset (any time, mid-pass included): state IDLE, accumulators, counter, membranes, spike_out, v_out, out_valid, busy, x_ready all 0.

## Timing
- Reset values: every output 0.
- x_ready combinational from state register only (no dependency on x_valid).
- First beat may be accepted the cycle after start is sampled; one beat per cycle max; x_valid gaps stall without loss.
- Last beat accepted at edge k: SCALE results at k+1, out_valid high from edge k+2. Minimum pass latency N_IN+3 cycles start-to-out_valid.
- out_valid & out_ready at edge m: IDLE from m, new start accepted at m+1 earliest.
- out_ready asserted without out_valid: no effect.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0, x_ready=0; release, start -> x_ready=1 next cycle.
- Uniform: all x=4, all w=16'h0100, b=0, clear_v -> I=12544 each, spike_out=10'h3FF, v_out=0 (RESET_MODE=0) / 8448 (RESET_MODE=1); out_valid at N_IN+3 cycles with no gaps.
- Threshold edge: x[0]=2, w[0]=16'h2000, others x=0; b[0]=0, b[1]=-1 -> neuron0 I=4096 spikes, neuron1 v=4095 no spike; repeat without clear_v -> neuron1 v=1023+4095=5118 spikes.
- Saturation: all x=7, w=16'h7FFF -> I=32767, spike, v_out=28671 (RESET_MODE=1); w=16'h8000 -> I=-32768, no spike, v_out=-32768; next pass with w=0, b=0 -> v=-8192.
- Handshake: x_valid toggling every other cycle gives identical result; out_ready low 5 cycles -> outputs stable, x_ready=0, start ignored, busy=1.
- Mid-pass reset after 20 beats -> all zero; fresh pass equals golden model from zero membranes.
